// File: rtl/joltage_stream_tx_pkg.sv
// Shared definitions for the joltage digit stream: ASCII codes, FSM states, beat widths.
package joltage_stream_tx_pkg;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;

    localparam int JOLT_W      = 4;
    localparam int BANK_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        FLUSH  = 3'd2,
        EOP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Digits '1'..'9' only; '0' is not a legal joltage.
    function automatic logic is_digit(input logic [7:0] b);
        return (b > CHAR_0) && (b <= CHAR_9);
    endfunction

endpackage

// File: rtl/joltage_stream_tx_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head and a flush input.
module joltage_stream_tx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/joltage_stream_tx.sv
// Joltage stream producer: buffers UART bytes, decodes digits/newlines into beats,
// and injects bank terminators and the end-of-puzzle marker.
module joltage_stream_tx
    import joltage_stream_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         IDLE_TIMEOUT = 1000000,
    parameter logic [7:0] EOT_CHAR     = 8'h04
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_valid,
    input  logic                  hold,
    output logic [JOLT_W-1:0]     joltage_out,
    output logic                  joltage_out_valid,
    output logic                  bank_end,
    output logic                  end_of_puzzle_tx,
    output logic                  busy,
    output logic                  fifo_overflow,
    output logic                  format_error,
    output logic [BANK_CNT_W-1:0] bank_count
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);

    state_t        state;
    logic [1:0]    digit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          clear;

    // DONE ignores the UART entirely; clearing on the EOP beat discards leftovers.
    assign push  = rx_byte_valid && !fifo_full && (state != DONE);
    assign pop   = (state == STREAM) && !hold && !fifo_empty;
    assign clear = (state == EOP) && !hold;

    joltage_stream_tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            digit_cnt         <= '0;
            idle_cnt          <= '0;
            joltage_out       <= '0;
            joltage_out_valid <= 1'b0;
            bank_end          <= 1'b0;
            end_of_puzzle_tx  <= 1'b0;
            busy              <= 1'b0;
            fifo_overflow     <= 1'b0;
            format_error      <= 1'b0;
            bank_count        <= '0;
        end else begin
            joltage_out       <= '0;
            joltage_out_valid <= 1'b0;
            bank_end          <= 1'b0;
            end_of_puzzle_tx  <= 1'b0;

            if (rx_byte_valid && fifo_full && (state != DONE)) begin
                fifo_overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (push) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end

                STREAM: begin
                    // Idle timer: any push restarts it, hold freezes it.
                    if (push) begin
                        idle_cnt <= '0;
                    end else if (!hold) begin
                        if (fifo_empty && !rx_byte_valid) begin
                            if (idle_cnt == TO_LAST) begin
                                idle_cnt <= '0;
                                state    <= FLUSH;
                            end else begin
                                idle_cnt <= idle_cnt + TW'(1);
                            end
                        end else begin
                            idle_cnt <= '0;
                        end
                    end

                    if (pop) begin
                        if (head == EOT_CHAR) begin
                            state <= FLUSH;
                        end else if (is_digit(head)) begin
                            joltage_out       <= head[3:0];
                            joltage_out_valid <= 1'b1;
                            if (digit_cnt != 2'd2) digit_cnt <= digit_cnt + 2'd1;
                        end else if (head == CHAR_LF) begin
                            if (digit_cnt != 2'd0) begin
                                joltage_out_valid <= 1'b1;
                                bank_end          <= 1'b1;
                                bank_count        <= bank_count + 16'd1;
                                if (digit_cnt == 2'd1) format_error <= 1'b1;
                            end
                            digit_cnt <= '0;
                        end else if ((head != CHAR_CR) && (head != CHAR_SP)) begin
                            format_error <= 1'b1;
                        end
                    end
                end

                FLUSH: begin
                    if (!hold) begin
                        if (digit_cnt != 2'd0) begin
                            joltage_out_valid <= 1'b1;
                            bank_end          <= 1'b1;
                            bank_count        <= bank_count + 16'd1;
                            digit_cnt         <= '0;
                        end
                        state <= EOP;
                    end
                end

                EOP: begin
                    if (!hold) begin
                        joltage_out_valid <= 1'b1;
                        end_of_puzzle_tx  <= 1'b1;
                        state             <= DONE;
                        busy              <= 1'b0;
                    end
                end

                DONE: begin
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joltage_stream_tx.sv
// Self-checking bench for joltage_stream_tx: directed scenarios plus randomized byte streams.
module tb_joltage_stream_tx;

    typedef logic [7:0] bq_t[$];

    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] BE_CODE  = 8'h40;
    localparam logic [7:0] EOP_CODE = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        hold;
    logic [3:0]  joltage_out;
    logic        joltage_out_valid;
    logic        bank_end;
    logic        end_of_puzzle_tx;
    logic        busy;
    logic        fifo_overflow;
    logic        format_error;
    logic [15:0] bank_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stray = 0;
    bit   eop_seen = 0;
    logic [7:0] got[$];
    int   got_cyc[$];
    bq_t  stim;
    logic [7:0] exp_q[$];
    int   m_banks;
    bit   m_ferr;

    always #5 clk = ~clk;

    joltage_stream_tx #(
        .FIFO_DEPTH   (16),
        .IDLE_TIMEOUT (8),
        .EOT_CHAR     (EOT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_byte           (rx_byte),
        .rx_byte_valid     (rx_byte_valid),
        .hold              (hold),
        .joltage_out       (joltage_out),
        .joltage_out_valid (joltage_out_valid),
        .bank_end          (bank_end),
        .end_of_puzzle_tx  (end_of_puzzle_tx),
        .busy              (busy),
        .fifo_overflow     (fifo_overflow),
        .format_error      (format_error),
        .bank_count        (bank_count)
    );

    // Beat recorder: {eop, bank_end, 00, digit}; any non-zero field outside a beat is stray.
    always @(negedge clk) begin
        cyc++;
        if (joltage_out_valid) begin
            got.push_back({end_of_puzzle_tx, bank_end, 2'b00, joltage_out});
            got_cyc.push_back(cyc);
            if (end_of_puzzle_tx) eop_seen = 1'b1;
        end else if ((joltage_out != 4'd0) || bank_end || end_of_puzzle_tx) begin
            stray++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_byte_valid = 1'b0;
        hold = 1'b0;
        tick(2);
        reset = 1'b0;
        got.delete();
        got_cyc.delete();
        eop_seen = 1'b0;
        stray = 0;
        stim.delete();
        tick(1);
    endtask

    task automatic stim_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic send_stim(input int maxgap, input bit hold_en);
        foreach (stim[i]) begin
            hold = hold_en && ($urandom_range(0, 3) == 0);
            rx_byte = stim[i];
            rx_byte_valid = 1'b1;
            @(negedge clk);
            rx_byte_valid = 1'b0;
            if (maxgap > 0) tick($urandom_range(0, maxgap));
        end
        hold = 1'b0;
    endtask

    // Reference: walk the byte string by the stream rules and list the beats it must produce.
    task automatic run_model(input bq_t s);
        int dc;
        exp_q.delete();
        m_banks = 0;
        m_ferr = 1'b0;
        dc = 0;
        foreach (s[i]) begin
            if (s[i] == EOT) break;
            if ((s[i] >= "1") && (s[i] <= "9")) begin
                exp_q.push_back(s[i] - "0");
                dc++;
            end else if (s[i] == LF) begin
                if (dc > 0) begin
                    exp_q.push_back(BE_CODE);
                    m_banks++;
                    if (dc == 1) m_ferr = 1'b1;
                end
                dc = 0;
            end else if ((s[i] != CR) && (s[i] != SP)) begin
                m_ferr = 1'b1;
            end
        end
        if (dc > 0) begin
            exp_q.push_back(BE_CODE);
            m_banks++;
        end
        exp_q.push_back(EOP_CODE);
    endtask

    task automatic wait_eop(input string tag, input int budget);
        int n = 0;
        while (!eop_seen && (n < budget)) begin
            tick(1);
            n++;
        end
        check({tag, "_eop_seen"}, 32'(eop_seen), 32'd1);
        tick(3);
    endtask

    task automatic check_end(input string tag, input bit exp_ovf);
        check({tag, "_nbeats"}, got.size(), exp_q.size());
        for (int i = 0; (i < got.size()) && (i < exp_q.size()); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        check({tag, "_bank_count"}, 32'(bank_count), 32'(m_banks));
        check({tag, "_format_error"}, 32'(format_error), 32'(m_ferr));
        check({tag, "_overflow"}, 32'(fifo_overflow), 32'(exp_ovf));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_stray"}, stray, 0);
    endtask

    initial begin
        int n_before;
        logic [15:0] bc_before;
        bit ferr_before;

        reset = 1'b1;
        rx_byte = 8'h00;
        rx_byte_valid = 1'b0;
        hold = 1'b0;
        tick(3);
        check("rst_valid", 32'(joltage_out_valid), 32'd0);
        check("rst_jolt", 32'(joltage_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({fifo_overflow, format_error, bank_end, end_of_puzzle_tx}), 32'd0);
        check("rst_bank_count", 32'(bank_count), 32'd0);
        reset = 1'b0;

        // Simple bank terminated by EOT
        do_reset();
        stim_str("987");
        stim.push_back(LF);
        stim.push_back(EOT);
        run_model(stim);
        send_stim(0, 1'b0);
        wait_eop("t1", 50);
        check_end("t1", 1'b0);

        // CR, blank line, and an unterminated bank closed by the idle timeout
        do_reset();
        stim_str("12");
        stim.push_back(CR);
        stim.push_back(LF);
        stim.push_back(LF);
        stim_str("34");
        run_model(stim);
        send_stim(0, 1'b0);
        wait_eop("t2", 100);
        check_end("t2", 1'b0);

        // Overflow under hold, then an unbroken drain
        do_reset();
        hold = 1'b1;
        stim_str("12345678912345678");
        foreach (stim[i]) begin
            rx_byte = stim[i];
            rx_byte_valid = 1'b1;
            @(negedge clk);
        end
        rx_byte_valid = 1'b0;
        tick(2);
        check("t3_overflow_held", 32'(fifo_overflow), 32'd1);
        check("t3_no_beats_held", got.size(), 0);
        check("t3_busy_held", 32'(busy), 32'd1);
        void'(stim.pop_back());
        run_model(stim);
        hold = 1'b0;
        wait_eop("t3", 100);
        check_end("t3", 1'b1);
        if (got_cyc.size() >= 16) check("t3_no_gaps", got_cyc[15] - got_cyc[0], 15);

        // Illegal characters
        do_reset();
        stim_str("3x05");
        stim.push_back(LF);
        stim.push_back(EOT);
        run_model(stim);
        send_stim(0, 1'b0);
        wait_eop("t4a", 50);
        check_end("t4a", 1'b0);

        // Single-digit bank
        do_reset();
        stim_str("7");
        stim.push_back(LF);
        stim.push_back(EOT);
        run_model(stim);
        send_stim(0, 1'b0);
        wait_eop("t4b", 50);
        check_end("t4b", 1'b0);

        // Reset in mid-stream after two digit beats
        do_reset();
        stim_str("4444");
        stim.push_back(LF);
        foreach (stim[i]) begin
            rx_byte = stim[i];
            rx_byte_valid = 1'b1;
            @(negedge clk);
            #1;
            if (got.size() >= 2) break;
        end
        rx_byte_valid = 1'b0;
        check("t5_two_beats", got.size(), 2);
        reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(joltage_out_valid), 32'd0);
        check("t5_async_jolt", 32'(joltage_out), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_bank_count", 32'(bank_count), 32'd0);
        tick(2);
        reset = 1'b0;
        got.delete();
        got_cyc.delete();
        eop_seen = 1'b0;
        stray = 0;
        tick(6);
        check("t5_quiet_after_reset", got.size(), 0);
        stim.delete();
        stim_str("21");
        stim.push_back(LF);
        stim.push_back(EOT);
        run_model(stim);
        send_stim(0, 1'b0);
        wait_eop("t5", 50);
        check_end("t5", 1'b0);

        // DONE ignores further input
        n_before = got.size();
        bc_before = bank_count;
        ferr_before = format_error;
        stim.delete();
        stim_str("99");
        stim.push_back(LF);
        stim.push_back(EOT);
        send_stim(0, 1'b0);
        tick(30);
        check("t6_no_beats", got.size(), n_before);
        check("t6_bank_count", 32'(bank_count), 32'(bc_before));
        check("t6_format_error", 32'(format_error), 32'(ferr_before));
        check("t6_overflow", 32'(fifo_overflow), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Randomized streams with gaps and short holds
        for (int it = 0; it < 8; it++) begin
            int len;
            do_reset();
            len = $urandom_range(4, 24);
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r <= 8)       stim.push_back(8'("1") + 8'(r));
                else if (r <= 10) stim.push_back(LF);
                else if (r == 11) stim.push_back(CR);
                else if (r == 12) stim.push_back(SP);
                else if (r == 13) stim.push_back("0");
                else if (r == 14) stim.push_back("q");
                else              stim.push_back(LF);
            end
            if ((it % 2) == 0) stim.push_back(EOT);
            run_model(stim);
            send_stim(3, 1'b1);
            wait_eop($sformatf("rnd%0d", it), 400);
            check_end($sformatf("rnd%0d", it), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
